// File: rtl/random_attack_ctrl.sv
// Random-shot controller: draws board cells from an 8-bit LFSR, reads the
// target cell, and marks it shot; falls back to a row-major scan after MAX_TRIES repeats.
module random_attack_ctrl #(
  parameter int         BOARD_DIM = 5,
  parameter int         MAX_TRIES = 8,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] target_player,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] mem_player,
  output logic [2:0] mem_row,
  output logic [2:0] mem_col,
  output logic [1:0] mem_wdata,
  input  logic       mem_gnt,
  input  logic       mem_rvalid,
  input  logic [1:0] mem_rdata,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic       fail
);

  localparam int               TRY_W     = $clog2(MAX_TRIES + 2);
  localparam logic [TRY_W-1:0] TRIES_LIM = TRY_W'(MAX_TRIES);
  localparam logic [3:0]       DIM       = 4'(BOARD_DIM);
  localparam logic [2:0]       LAST      = 3'(BOARD_DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_RD_REQ, S_RD_WAIT, S_DECIDE, S_WR_REQ, S_DONE, S_REARM
  } state_t;

  state_t           r_state;
  logic [7:0]       r_lfsr;
  logic [TRY_W-1:0] r_tries;
  logic [2:0]       r_scan_row;
  logic [2:0]       r_scan_col;
  logic [1:0]       r_player;
  logic [2:0]       r_row;
  logic [2:0]       r_col;
  logic [1:0]       r_code;
  logic [1:0]       r_wdata;
  logic             r_mem_req;
  logic             r_mem_we;
  logic             r_busy;
  logic             r_done;
  logic             r_hit;
  logic             r_fail;

  logic       w_fb;
  logic [2:0] w_cand_row;
  logic [2:0] w_cand_col;
  logic       w_cand_ok;
  logic       w_scan_mode;
  logic       w_scan_last;

  // x^8+x^6+x^5+x^4+1 in Fibonacci form, shifting toward the MSB
  assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_cand_row  = r_lfsr[2:0];
  assign w_cand_col  = r_lfsr[5:3];
  assign w_cand_ok   = ({1'b0, w_cand_row} < DIM) && ({1'b0, w_cand_col} < DIM);
  assign w_scan_mode = (r_tries == TRIES_LIM);
  assign w_scan_last = (r_scan_row == LAST) && (r_scan_col == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= SEED;
      r_tries    <= '0;
      r_scan_row <= '0;
      r_scan_col <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hit      <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_player   <= target_player;
            r_tries    <= '0;
            r_scan_row <= '0;
            r_scan_col <= '0;
            r_hit      <= 1'b0;
            r_fail     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_GEN;
          end
        end
        S_GEN: begin
          if (!start) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_scan_mode) begin
            r_row     <= r_scan_row;
            r_col     <= r_scan_col;
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b0;
            r_state   <= S_RD_REQ;
          end else if (w_cand_ok) begin
            r_row     <= w_cand_row;
            r_col     <= w_cand_col;
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b0;
            r_state   <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (!start) begin
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          // Aborting here drops the outstanding response; IDLE never samples rvalid
          if (!start) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (mem_rvalid) begin
            r_code  <= mem_rdata;
            r_state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (!start) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!r_code[1]) begin
            r_wdata   <= {1'b1, r_code[0]};
            r_hit     <= r_code[0];
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b1;
            r_state   <= S_WR_REQ;
          end else if (w_scan_mode) begin
            if (w_scan_last) begin
              r_fail  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              if (r_scan_col == LAST) begin
                r_scan_col <= '0;
                r_scan_row <= r_scan_row + 3'd1;
              end else begin
                r_scan_col <= r_scan_col + 3'd1;
              end
              r_state <= S_GEN;
            end
          end else begin
            r_tries <= r_tries + 1'b1;
            r_state <= S_GEN;
          end
        end
        S_WR_REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_REARM;
        end
        S_REARM: begin
          if (!start) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_player = r_player;
  assign mem_row    = r_row;
  assign mem_col    = r_col;
  assign mem_wdata  = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign hit        = r_hit;
  assign fail       = r_fail;

endmodule
